// File: rtl/mouse_mmio_pkg.sv
// Shared definitions for the memory-mapped mouse peripheral: register
// offsets, PS/2 status-byte bit positions, packet FSM states and a clamp helper.
package mouse_mmio_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_POSX   = 2'd1;
    localparam logic [1:0] OFF_POSY   = 2'd2;

    // Bit positions inside the first (status) byte of a PS/2 movement packet
    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Packet assembly states
    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        APPLY
    } pkt_state_e;

    // Clamp a signed 16-bit value into [0, max_v]; negative values give 0.
    function automatic logic [15:0] clamp_s16(input logic signed [15:0] v,
                                              input logic [15:0]        max_v);
        logic [15:0] mag;
        mag = $unsigned(v);
        if (v[15])
            return 16'd0;
        else if (mag > max_v)
            return max_v;
        else
            return mag;
    endfunction

endpackage

// File: rtl/mouse_packet_rx.sv
// Assembles 3-byte PS/2 movement packets from the byte receiver. Bytes without
// the sync bit are dropped while hunting for a packet start, and a stalled
// partial packet is discarded after TIMEOUT idle cycles.
module mouse_packet_rx
    import mouse_mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       pkt_valid,
    output logic [7:0] pkt_status,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    pkt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    dx_q, dx_d;
    logic [7:0]    dy_q, dy_d;

    // State and packet byte registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_B0;
            cnt_q    <= '0;
            status_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    // Next-state logic: byte capture, resync and inter-byte timeout
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        dx_d     = dx_q;
        dy_d     = dy_q;

        unique case (state_q)
            // APPLY lasts one cycle and accepts a new first byte just like
            // WAIT_B0, so back-to-back packets lose nothing.
            WAIT_B0, APPLY: begin
                state_d = WAIT_B0;
                cnt_d   = '0;
                if (rx_valid && rx_byte[SYNC]) begin
                    status_d = rx_byte;
                    state_d  = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (rx_valid) begin
                    dx_d    = rx_byte;
                    cnt_d   = '0;
                    state_d = WAIT_B2;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    dy_d    = rx_byte;
                    cnt_d   = '0;
                    state_d = APPLY;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_B0;
                cnt_d   = '0;
            end
        endcase
    end

    assign pkt_valid  = (state_q == APPLY);
    assign pkt_status = status_q;
    assign pkt_dx     = {status_q[XSIGN], dx_q};
    assign pkt_dy     = {status_q[YSIGN], dy_q};

endmodule

// File: rtl/mouse_mmio.sv
// Memory-mapped mouse peripheral: integrates PS/2 packets into a clamped
// screen position, latches left clicks and answers CPU loads and stores at
// BASE_ADDR (status), BASE_ADDR+1 (posX) and BASE_ADDR+2 (posY).
module mouse_mmio
    import mouse_mmio_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 16384,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned X_INIT    = 320,
    parameter int unsigned Y_INIT    = 240,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic [15:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid
);

    localparam logic [15:0] XMAX16 = 16'(X_MAX);
    localparam logic [15:0] YMAX16 = 16'(Y_MAX);

    logic       pkt_valid;
    logic [7:0] pkt_status;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;

    mouse_packet_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_packet_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .pkt_valid  (pkt_valid),
        .pkt_status (pkt_status),
        .pkt_dx     (pkt_dx),
        .pkt_dy     (pkt_dy)
    );

    logic [15:0] pos_x_q, pos_x_d;
    logic [15:0] pos_y_q, pos_y_d;
    logic        click_q, click_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    // Address decode: offset from the base wraps, so one compare covers the range
    logic [15:0] off;
    logic        hit;
    logic        rd_hit;
    logic        wr_hit;

    assign off    = addr - 16'(BASE_ADDR);
    assign hit    = (off <= 16'd2);
    assign rd_hit = hit && rd_en;
    assign wr_hit = hit && wr_en;

    // Packet arithmetic in 12-bit signed; positions never exceed 11 bits
    logic signed [11:0] new_x;
    logic signed [11:0] new_y;

    assign new_x = $signed({1'b0, pos_x_q[10:0]}) + $signed({{3{pkt_dx[8]}}, pkt_dx});
    // PS/2 positive Y is up; screen Y grows downward
    assign new_y = $signed({1'b0, pos_y_q[10:0]}) - $signed({{3{pkt_dy[8]}}, pkt_dy});

    // Position, button, click and read-response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q    <= 16'(X_INIT);
            pos_y_q    <= 16'(Y_INIT);
            click_q    <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            click_q    <= click_d;
            left_q     <= left_d;
            right_q    <= right_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Register updates: packet first, then CPU writes override their axis
    always_comb begin
        logic click_set;
        logic click_clr;

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        left_d  = left_q;
        right_d = right_q;

        if (pkt_valid) begin
            if (!pkt_status[XOVF])
                pos_x_d = clamp_s16({{4{new_x[11]}}, new_x}, XMAX16);
            if (!pkt_status[YOVF])
                pos_y_d = clamp_s16({{4{new_y[11]}}, new_y}, YMAX16);
            left_d  = pkt_status[LEFT];
            right_d = pkt_status[RIGHT];
        end

        if (wr_hit && off[1:0] == OFF_POSX)
            pos_x_d = clamp_s16($signed(wr_data), XMAX16);
        if (wr_hit && off[1:0] == OFF_POSY)
            pos_y_d = clamp_s16($signed(wr_data), YMAX16);

        // A new left press outranks a clear from a status read or write
        click_set = pkt_valid && pkt_status[LEFT] && !left_q;
        click_clr = (rd_hit && off[1:0] == OFF_STATUS) ||
                    (wr_hit && off[1:0] == OFF_STATUS && !wr_data[0]);

        if (click_set)
            click_d = 1'b1;
        else if (click_clr)
            click_d = 1'b0;
        else
            click_d = click_q;
    end

    // Read response: data sampled from current registers, returned next cycle
    always_comb begin
        rd_valid_d = rd_hit;
        rd_data_d  = '0;
        if (rd_hit) begin
            case (off[1:0])
                OFF_STATUS: rd_data_d = {13'b0, right_q, left_q, click_q};
                OFF_POSX:   rd_data_d = pos_x_q;
                default:    rd_data_d = pos_y_q;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mouse_mmio.sv
// Directed bench for mouse_mmio: packet integration, clamping, click latch,
// resync, timeout and CPU read/write interactions.
module tb_mouse_mmio;

    localparam int unsigned TIMEOUT = 4095;
    localparam logic [15:0] A_STAT  = 16'd16384;
    localparam logic [15:0] A_POSX  = 16'd16385;
    localparam logic [15:0] A_POSY  = 16'd16386;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    mouse_mmio dut (
        .clk      (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    // Full packet plus the APPLY cycle
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        tick();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, {15'b0, rd_valid}, 16'd1);
        check(tag, rd_data, exp);
    endtask

    task automatic cpu_read_miss(input logic [15:0] a, input string tag);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, {15'b0, rd_valid}, 16'd0);
        check({tag, "_data"}, rd_data, 16'd0);
    endtask

    initial begin
        rst = 1'b1; rx_byte = '0; rx_valid = 1'b0;
        addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        repeat (3) tick();
        check("rst_rd_valid", {15'b0, rd_valid}, 16'd0);
        check("rst_rd_data", rd_data, 16'd0);
        rst = 1'b0;
        tick();

        // Reset values
        cpu_read(A_POSX, 16'd320, "rst_posx");
        tick();
        check("idle_rd_valid", {15'b0, rd_valid}, 16'd0);
        check("idle_rd_data", rd_data, 16'd0);
        cpu_read(A_POSY, 16'd240, "rst_posy");
        cpu_read(A_STAT, 16'd0, "rst_stat");
        cpu_read_miss(16'd16387, "miss_hi");
        cpu_read_miss(16'd16383, "miss_lo");
        cpu_write(16'd16387, 16'd5);

        // Left press with movement
        send_pkt(8'h09, 8'h05, 8'h03);
        cpu_read(A_POSX, 16'd325, "pkt1_posx");
        cpu_read(A_POSY, 16'd237, "pkt1_posy");
        cpu_read(A_STAT, 16'd3, "pkt1_stat");
        cpu_read(A_STAT, 16'd2, "pkt1_stat_clr");

        // Negative dx clamps at 0; negative write clamps at 0
        cpu_write(A_POSX, 16'd10);
        send_pkt(8'h18, 8'hEC, 8'h00);
        cpu_read(A_POSX, 16'd0, "neg_clamp_x");
        cpu_read(A_STAT, 16'd0, "release_stat");
        cpu_write(A_POSY, 16'hFFF9);
        cpu_read(A_POSY, 16'd0, "wr_neg_y");

        // Stray byte dropped, then packet applies
        cpu_write(A_POSY, 16'd100);
        send_byte(8'h00);
        send_pkt(8'h08, 8'h01, 8'h01);
        cpu_read(A_POSX, 16'd1, "resync_x");
        cpu_read(A_POSY, 16'd99, "resync_y");

        // Timeout discards partial packet
        send_byte(8'h08);
        send_byte(8'h05);
        repeat (TIMEOUT) tick();
        send_pkt(8'h08, 8'h02, 8'h00);
        cpu_read(A_POSX, 16'd3, "timeout_x");
        cpu_read(A_POSY, 16'd99, "timeout_y");

        // One idle cycle short of the timeout keeps the packet
        send_byte(8'h08);
        send_byte(8'h03);
        repeat (TIMEOUT - 1) tick();
        send_byte(8'h00);
        tick();
        cpu_read(A_POSX, 16'd6, "no_timeout_x");

        // Upper clamps
        cpu_write(A_POSX, 16'd630);
        send_pkt(8'h08, 8'h10, 8'h00);
        cpu_read(A_POSX, 16'd639, "max_clamp_x");
        cpu_write(A_POSX, 16'd1000);
        cpu_read(A_POSX, 16'd639, "wr_clamp_x");
        cpu_write(A_POSY, 16'd500);
        cpu_read(A_POSY, 16'd479, "wr_clamp_y");
        cpu_write(A_POSY, 16'd99);

        // X overflow: no X movement
        send_pkt(8'h48, 8'h10, 8'h00);
        cpu_read(A_POSX, 16'd639, "ovf_x");

        // X overflow + left, CPU write of posX during APPLY; Y still moves
        send_byte(8'h49);
        send_byte(8'h10);
        send_byte(8'h04);
        cpu_write(A_POSX, 16'd100);
        cpu_read(A_POSX, 16'd100, "apply_wr_x");
        cpu_read(A_POSY, 16'd95, "apply_y");
        cpu_read(A_STAT, 16'd3, "ovf_click");

        // Read and write together: read returns pre-write value
        addr = A_POSX; wr_data = 16'd200; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdwr_valid", {15'b0, rd_valid}, 16'd1);
        check("rdwr_data", rd_data, 16'd100);
        cpu_read(A_POSX, 16'd200, "rdwr_after");

        // Status writes: 1 does nothing, 0 clears click
        send_pkt(8'h08, 8'h00, 8'h00);
        send_pkt(8'h09, 8'h00, 8'h00);
        cpu_write(A_STAT, 16'd1);
        cpu_read(A_STAT, 16'd3, "stat_wr1");
        send_pkt(8'h08, 8'h00, 8'h00);
        send_pkt(8'h09, 8'h00, 8'h00);
        cpu_write(A_STAT, 16'd0);
        cpu_read(A_STAT, 16'd2, "stat_wr0");

        // Status read in the APPLY cycle that sets click: set wins
        send_pkt(8'h08, 8'h00, 8'h00);
        send_byte(8'h09);
        send_byte(8'h00);
        send_byte(8'h00);
        cpu_read(A_STAT, 16'd0, "set_vs_clr_pre");
        cpu_read(A_STAT, 16'd3, "set_vs_clr_post");

        // Back-to-back packets: first byte of second arrives during APPLY
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h02); send_byte(8'h00);
        tick();
        cpu_read(A_POSX, 16'd203, "b2b_x");

        // Reset mid-packet discards it
        send_byte(8'h08);
        send_byte(8'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h01);
        send_byte(8'h00);
        tick();
        cpu_read(A_POSX, 16'd320, "midrst_x");
        cpu_read(A_POSY, 16'd240, "midrst_y");
        cpu_read(A_STAT, 16'd0, "midrst_stat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
